// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU constants, field widths and the int-to-fp normalizer FSM states.
package fpu_pkg;
    localparam int EXP_W = 8;
    localparam int FRAC_W = 23;
    localparam logic [EXP_W-1:0] FP32_EXP_BIAS = 8'd127;
    localparam logic [EXP_W-1:0] INT_CVT_EXP_INIT = 8'd158;
    typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;
endpackage

// File: rtl/int_to_fp_normalizer.sv
// int_to_fp_normalizer: normalizes a 32-bit integer into sign/exponent/mantissa candidate for rounding.
// Define INT_TO_FP_UNSIGNED_EN to add the in_unsigned port for unsigned conversion.
module int_to_fp_normalizer
    import fpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic [1:0]            in_rm,
`ifdef INT_TO_FP_UNSIGNED_EN
    input  logic                  in_unsigned,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W:0]        out_sign_and_exp,
    output logic [FRAC_W+8:0]     out_mantissa_candidate,
    output logic                  out_is_zero,
    output logic [1:0]            out_rm
);
    state_t state;
    logic sign;
    logic [31:0] mag;
    logic [EXP_W-1:0] exp;
    logic neg;
`ifdef INT_TO_FP_UNSIGNED_EN
    assign neg = in_data[31] & ~in_unsigned;
`else
    assign neg = in_data[31];
`endif
    assign in_ready = state == IDLE;
    assign out_valid = state == HOLD;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sign <= 1'b0;
            mag <= '0;
            exp <= '0;
            out_sign_and_exp <= '0;
            out_mantissa_candidate <= '0;
            out_is_zero <= 1'b0;
            out_rm <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign <= neg;
                    mag <= neg ? -in_data : in_data;
                    exp <= INT_CVT_EXP_INIT;
                    out_rm <= in_rm;
                    if (in_data == '0) begin
                        state <= HOLD;
                        out_is_zero <= 1'b1;
                        out_sign_and_exp <= '0;
                        out_mantissa_candidate <= '0;
                    end else begin
                        state <= NORM;
                    end
                end
                // Byte-wide shifts first keep the worst case at 10 steps.
                NORM: if (mag[31]) begin
                    state <= HOLD;
                    out_sign_and_exp <= {sign, exp};
                    out_mantissa_candidate <= {mag[30:0], 1'b0};
                    out_is_zero <= 1'b0;
                end else if (mag[31:24] == 8'd0) begin
                    mag <= mag << 8;
                    exp <= exp - 8'd8;
                end else begin
                    mag <= mag << 1;
                    exp <= exp - 8'd1;
                end
                HOLD: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
